aes_inv_key_sched: RTL and testbench

Sequential AES-128 inverse key schedule for the decryption datapath. It accepts the 128-bit cipher key and runs the forward expansion iteratively, one round per cycle, to reach the round-10 key. It then walks the schedule backwards and streams round keys 10 down to 0 over a valid/ready interface, which is the order the inverse cipher consumes them. Forward and inverse steps share one 4-byte S-box (SubWord) instance.

---
 rtl/aes_inv_key_sched.sv | 264 ++++++++++++++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: sequential AES-128 inverse key schedule.
// The forward expansion runs one round per cycle up to the round-10 key.
// The schedule is then walked backwards, and round keys 10..0 are streamed
// over a valid/ready interface. The forward and inverse steps share one
// SubWord (4-byte S-box) instance.
// Optional macro AES_INV_KEY_EQUIV_EN: rounds 1..9 are output with
// InvMixColumns applied (equivalent-inverse-cipher keys).
module aes_inv_key_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_round,
   output logic         rk_last
);

   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RND_W  = 4;
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_REV  = 2'd2
   } state_t;

   // AES S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte substitution through the table
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   // SubWord applied bytewise
   function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // RotWord: one byte rotate left
   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Round constant for round index 1..10
   function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
      logic [7:0] r;
      r = 8'h00;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

`ifdef AES_INV_KEY_EQUIV_EN
   // Multiply by x in GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // InvMixColumns on one column, row 0 in bits [31:24]
   function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // InvMixColumns over all four columns
   function automatic logic [KEY_W-1:0] inv_mix(input logic [KEY_W-1:0] k);
      return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
              inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
   endfunction
`endif

   state_t             r_state;
   logic [KEY_W-1:0]   r_key;
   logic [RND_W-1:0]   r_rc;
   logic               r_busy;
   logic               r_valid;
   logic               r_last;
   logic [RND_W-1:0]   r_round;
   logic [KEY_W-1:0]   r_data;

   state_t             w_state_nxt;
   logic [KEY_W-1:0]   w_key_nxt;
   logic [RND_W-1:0]   w_rc_nxt;
   logic               w_busy_nxt;
   logic               w_valid_nxt;
   logic               w_last_nxt;
   logic [RND_W-1:0]   w_round_nxt;
   logic [KEY_W-1:0]   w_data_nxt;

   logic [WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
   logic [WORD_W-1:0]  w_d;
   logic [WORD_W-1:0]  w_sub_src;
   logic [WORD_W-1:0]  w_sub_out;
   logic [RND_W-1:0]   w_rc_inc;
   logic [RND_W-1:0]   w_rcon_idx;
   logic [WORD_W-1:0]  w_rcon_word;
   logic [WORD_W-1:0]  w_f0, w_f1, w_f2, w_f3;
   logic [KEY_W-1:0]   w_fwd_key;
   logic [KEY_W-1:0]   w_inv_key;

   // Shared SubWord datapath for the forward and inverse round steps
   always_comb begin
      w_w0        = r_key[127:96];
      w_w1        = r_key[95:64];
      w_w2        = r_key[63:32];
      w_w3        = r_key[31:0];
      w_d         = w_w3 ^ w_w2;
      w_rc_inc    = RND_W'(r_rc + RND_W'(1));
      w_sub_src   = (r_state == ST_REV) ? w_d : w_w3;
      w_sub_out   = sub_word(rot_word(w_sub_src));
      w_rcon_idx  = (r_state == ST_REV) ? r_rc : w_rc_inc;
      w_rcon_word = {rcon(w_rcon_idx), 24'h000000};
      w_f0        = w_w0 ^ w_sub_out ^ w_rcon_word;
      w_f1        = w_w1 ^ w_f0;
      w_f2        = w_w2 ^ w_f1;
      w_f3        = w_w3 ^ w_f2;
      w_fwd_key   = {w_f0, w_f1, w_f2, w_f3};
      w_inv_key   = {w_w0 ^ w_sub_out ^ w_rcon_word, w_w1 ^ w_w0, w_w2 ^ w_w1, w_d};
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_rc_nxt    = r_rc;
      w_busy_nxt  = r_busy;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_round_nxt = r_round;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_FWD;
               w_key_nxt   = key_in;
               w_rc_nxt    = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_FWD: begin
            w_key_nxt = w_fwd_key;
            w_rc_nxt  = w_rc_inc;
            if (w_rc_inc == LAST_RND) begin
               w_state_nxt = ST_REV;
               w_valid_nxt = 1'b1;
               w_round_nxt = LAST_RND;
               w_last_nxt  = 1'b0;
            end
         end
         ST_REV: begin
            if (rk_ready) begin
               if (r_rc == '0) begin
                  w_state_nxt = ST_IDLE;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_key_nxt   = w_inv_key;
                  w_rc_nxt    = RND_W'(r_rc - RND_W'(1));
                  w_round_nxt = RND_W'(r_rc - RND_W'(1));
                  w_last_nxt  = (r_rc == RND_W'(1));
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output key: plain, or InvMixColumns form for the middle rounds
   always_comb begin
`ifdef AES_INV_KEY_EQUIV_EN
      if ((w_state_nxt == ST_REV) && (w_round_nxt != '0) && (w_round_nxt != LAST_RND)) begin
         w_data_nxt = inv_mix(w_key_nxt);
      end else begin
         w_data_nxt = w_key_nxt;
      end
`else
      w_data_nxt = w_key_nxt;
`endif
   end

   // State, key and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_key   <= '0;
         r_rc    <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_round <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_rc    <= w_rc_nxt;
         r_busy  <= w_busy_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
         r_round <= w_round_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign busy     = r_busy;
   assign rk_valid = r_valid;
   assign rk_last  = r_last;
   assign rk_round = r_round;
   assign rk_data  = r_data;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Testbench for aes_inv_key_sched: random keys and random backpressure
// against a reference key expansion built from GF(2^8) arithmetic.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_round;
   logic         rk_last;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];
   logic [127:0] got_rk [11];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

   aes_inv_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_data  (rk_data),
      .rk_round (rk_round),
      .rk_last  (rk_last)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // S-box from multiplicative inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         if (x == 0) inv = 8'h00;
         else for (int e = 0; e < 253; e++) inv = gmul(inv, 8'(x));
         if (x != 0) inv = gmul(inv, 8'(x));
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // Standard FIPS-197 forward expansion into 11 round keys
   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

`ifdef AES_INV_KEY_EQUIV_EN
   function automatic logic [127:0] imc_model(input logic [127:0] k);
      logic [7:0]   m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] res = '0;
      logic [7:0]   acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - r + 4) % 4], k[127-32*c-8*j -: 8]);
            res[127-32*c-8*r -: 8] = acc;
         end
      return res;
   endfunction
`endif

   function automatic logic [127:0] exp_out(input int k);
`ifdef AES_INV_KEY_EQUIV_EN
      if (k >= 1 && k <= 9) return imc_model(exp_rk[k]);
`endif
      return exp_rk[k];
   endfunction

   // One full schedule: start, forward latency, then the 11-key stream
   task automatic run_stream(input logic [127:0] key, input bit rand_ready, input bit poke_start);
      int cnt;
      int k;
      bit rdy;
      expand(key);
      key_in = key;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      check_val("busy_after_start", 128'(busy), 128'(1));
      cnt = 0;
      while (!rk_valid && cnt < 40) begin
         if (poke_start && cnt == 3) begin
            start  = 1'b1;
            key_in = '0;
         end else begin
            start = 1'b0;
         end
         rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         cnt++;
      end
      start = 1'b0;
      check_val("fwd_latency", 128'(cnt), 128'(10));
      k = 10;
      cnt = 0;
      while (k >= 0 && cnt < 300) begin
         rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         check_val($sformatf("valid_r%0d", k), 128'(rk_valid), 128'(1));
         check_val($sformatf("round_r%0d", k), 128'(rk_round), 128'(k));
         check_val($sformatf("last_r%0d", k), 128'(rk_last), 128'(k == 0));
         check_val($sformatf("data_r%0d", k), rk_data, exp_out(k));
         got_rk[k] = rk_data;
         @(posedge clk); #1;
         cnt++;
         if (rdy) k--;
      end
      check_val("stream_done", 128'(k + 1), 128'(0));
      check_val("busy_after_last", 128'(busy), 128'(0));
      check_val("valid_after_last", 128'(rk_valid), 128'(0));
   endtask

   initial begin
      int cnt;
      build_sbox();
      rst      = 1'b1;
      start    = 1'b0;
      rk_ready = 1'b0;
      key_in   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_valid", 128'(rk_valid), 128'(0));
      check_val("rst_last", 128'(rk_last), 128'(0));
      check_val("rst_round", 128'(rk_round), 128'(0));
      check_val("rst_data", rk_data, 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // FIPS-197 key with ready held high
      run_stream(FIPS_KEY, 1'b0, 1'b0);
      check_val("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_val("fips_r0", got_rk[0], FIPS_KEY);
`ifndef AES_INV_KEY_EQUIV_EN
      check_val("fips_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
`endif
      repeat (2) @(posedge clk);
      #1;

      // Backpressure on the same key
      run_stream(FIPS_KEY, 1'b1, 1'b0);
      check_val("bp_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_val("bp_r0", got_rk[0], FIPS_KEY);

      // Second start during FWD must be ignored
      run_stream(FIPS_KEY, 1'b1, 1'b1);

      // Async reset while presenting round 6
      expand(FIPS_KEY);
      key_in   = FIPS_KEY;
      start    = 1'b1;
      rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt   = 0;
      while (!(rk_valid && rk_round == 4'd6) && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_val("reach_r6", 128'(cnt < 40), 128'(1));
      check_val("pre_rst_r6", rk_data, exp_out(6));
      #2 rst = 1'b1;
      #1;
      check_val("arst_valid", 128'(rk_valid), 128'(0));
      check_val("arst_busy", 128'(busy), 128'(0));
      check_val("arst_data", rk_data, 128'(0));
      check_val("arst_round", 128'(rk_round), 128'(0));
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("post_rst_valid", 128'(rk_valid), 128'(0));
         check_val("post_rst_busy", 128'(busy), 128'(0));
      end
      run_stream(SEQ_KEY, 1'b0, 1'b0);
      check_val("seq_r10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Back-to-back schedules with random keys, started on the first IDLE cycle
      for (int n = 0; n < 4; n++) begin
         run_stream({$urandom, $urandom, $urandom, $urandom}, 1'(n % 2), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
